timer_reg_if: RTL and testbench
===============================

TIMER_REG_IF -- requirements
Module: timer_reg_if

Interface
REQ-001 SHALL have parameter CNT_W, default 8, counter and register data width.
REQ-002 SHALL have port pclk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port preset_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have APB slave inputs psel (1), penable (1), pwrite (1), paddr (8), pwdata (CNT_W).
REQ-005 SHALL have APB slave outputs prdata (CNT_W), pready (1) and pslverr (1).
REQ-006 SHALL have counter-control outputs en (1), load (1), updown (1), cks (2) and tdr (CNT_W).
REQ-007 SHALL have input cnt (CNT_W), the live counter value.
REQ-008 SHALL have interrupt outputs tmr_ovf (1) and tmr_udf (1).

Function
REQ-009 SHALL define the access phase as psel=1 with penable=1, and SHALL drive pready=1 combinationally in the access phase (zero wait states).
REQ-010 SHALL commit a write at the pclk edge that ends the access phase; setup-phase (penable=0) cycles SHALL have no effect.
REQ-011 SHALL implement the register map: 0x00 TDR (RW), 0x01 TCR (RW), 0x02 TSR (R/W1C), 0x03 TIE (RW), and 0x04 TCNT (RO).
REQ-012 SHALL implement TCR as: bit0 en, bit1 load, bit2 updown, bits4:3 cks; bits 7:5 SHALL read as 0.
REQ-013 SHALL drive en, updown, cks and tdr directly from the TDR/TCR flops.
REQ-014 SHALL make load self-clearing: writing TCR bit1=1 SHALL raise load for exactly one pclk cycle after the write edge, and TCR bit1 SHALL read back 0.
REQ-015 SHALL register cnt each cycle into cnt_q.
REQ-016 SHALL detect overflow when updown=1, cnt_q equals all-ones and cnt equals 0.
REQ-017 SHALL detect underflow when updown=0, cnt_q equals 0 and cnt equals all-ones.
REQ-018 SHALL suppress overflow and underflow detection in the cycle following a load pulse, and whenever en=0.
REQ-019 SHALL make TSR bit0 (ovf) and TSR bit1 (udf) sticky once set; TSR bits 7:2 SHALL read as 0.
REQ-020 SHALL clear a TSR bit when 1 is written to it; writing 0 SHALL leave it unchanged.
REQ-021 SHALL let set win when a flag-set event and a W1C write to the same bit coincide; that bit SHALL remain 1.
REQ-022 SHALL drive tmr_ovf = TSR[0] & TIE[0] and tmr_udf = TSR[1] & TIE[1], combinationally from the flops.
REQ-023 SHALL return TCNT reads as the current cnt, combinationally.
REQ-024 SHALL drive prdata with the addressed register during an access-phase read, and 0 otherwise.
REQ-025 SHALL, on an access to an unmapped address or a write to TCNT, assert pslverr=1 in the access phase, change no state and drive prdata=0; pslverr SHALL be 0 at all other times.

Reset
REQ-026 SHALL clear TDR, TCR, TSR, TIE and cnt_q to 0 asynchronously while preset_n=0.
REQ-027 SHALL hold en, load, updown, cks, tdr, tmr_ovf, tmr_udf, prdata and pslverr at 0 while preset_n=0.
REQ-028 SHALL abort a reset asserted mid-transfer with no write committed, and SHALL discard any pending load pulse.
REQ-029 SHALL, on the first access after reset deassertion, behave exactly as on a fresh bus.

Structure
REQ-030 SHALL place the register address constants (ADDR_TDR..ADDR_TCNT) and the TCR/TSR bit-position constants in shared package timer_pkg.
REQ-031 SHALL place wrap detection (cnt_q flop, ovf/udf pulse generation, suppression) in one sub-module, timer_wrap_detect; all other logic SHALL be in timer_reg_if.

Verification
REQ-032 Write TDR=0x03, then TCR=0x0F -> tdr=0x03, en=1, updown=1, cks=2'b01; load high exactly one cycle; TCR reads 0x0D.
REQ-033 Up-count with TIE=0x01 and cnt stepping 0xFE,0xFF,0x00 -> TSR=0x01 and tmr_ovf=1; write TSR=0x01 -> TSR=0x00 and tmr_ovf=0.
REQ-034 Down-count with cnt stepping 0x01,0x00,0xFF and a W1C of bit1 in the wrap cycle -> TSR[1] remains 1; tmr_udf stays 0 while TIE=0.
REQ-035 Load with tdr=0xFF while cnt goes 0x00->0xFF (updown=0) -> no udf flag.
REQ-036 Read of 0x07 and write to 0x04 -> pslverr=1 and prdata=0 in the access phase; no register changes.
REQ-037 preset_n pulsed low for 140 ns during a TCR write access phase -> all outputs 0, TCR reads 0x00 afterwards, no load pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the timer register interface.
package timer_pkg;

    // Register addresses on the APB bus
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TIE  = 8'h03;
    localparam logic [7:0] ADDR_TCNT = 8'h04;

    // Timer control register fields
    localparam int TCR_EN_BIT     = 0;
    localparam int TCR_LOAD_BIT   = 1;
    localparam int TCR_UPDOWN_BIT = 2;
    localparam int TCR_CKS_LSB    = 3;
    localparam int TCR_CKS_MSB    = 4;

    // Timer status register flags
    localparam int TSR_OVF_BIT = 0;
    localparam int TSR_UDF_BIT = 1;

endpackage

// File: rtl/timer_wrap_detect.sv
// Detects counter wrap-around by comparing the live count with last cycle's
// count. A wrap caused by a load (counter jumping to tdr) is not a real wrap,
// so detection is masked for the cycle after a load pulse and while disabled.
module timer_wrap_detect #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    output logic             ovf_pulse,
    output logic             udf_pulse
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_dly_q, load_dly_d;

    // Next values: sample the live count and remember whether load was high.
    always_comb begin
        cnt_d      = cnt;
        load_dly_d = load;
    end

    // Previous-count and delayed-load registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            load_dly_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_dly_q <= load_dly_d;
        end
    end

    // Wrap pulses: all-ones to zero counting up, zero to all-ones counting down.
    always_comb begin
        ovf_pulse = 1'b0;
        udf_pulse = 1'b0;
        if (en && !load_dly_q) begin
            ovf_pulse =  updown && (cnt_q == '1) && (cnt == '0);
            udf_pulse = !updown && (cnt_q == '0) && (cnt == '1);
        end
    end

endmodule

// File: rtl/timer_reg_if.sv
// APB register interface for an external timer counter: holds the reload
// value, control bits, sticky wrap flags and interrupt enables.
module timer_reg_if #(
    parameter int CNT_W = 8
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [7:0]       paddr,
    input  logic [CNT_W-1:0] pwdata,
    output logic [CNT_W-1:0] prdata,
    output logic             pready,
    output logic             pslverr,
    output logic             en,
    output logic             load,
    output logic             updown,
    output logic [1:0]       cks,
    output logic [CNT_W-1:0] tdr,
    input  logic [CNT_W-1:0] cnt,
    output logic             tmr_ovf,
    output logic             tmr_udf
);

    import timer_pkg::*;

    logic [CNT_W-1:0] tdr_q, tdr_d;
    logic             en_q, en_d;
    logic             updown_q, updown_d;
    logic [1:0]       cks_q, cks_d;
    logic             load_q, load_d;
    logic [1:0]       tsr_q, tsr_d;
    logic [CNT_W-1:0] tie_q, tie_d;

    logic             access;
    logic             addr_ok;
    logic             slv_err;
    logic             wr_en;
    logic             rd_en;
    logic [CNT_W-1:0] rd_mux;
    logic             ovf_pulse;
    logic             udf_pulse;

    timer_wrap_detect #(.CNT_W(CNT_W)) u_wrap (
        .clk       (pclk),
        .rst_n     (preset_n),
        .cnt       (cnt),
        .en        (en_q),
        .updown    (updown_q),
        .load      (load_q),
        .ovf_pulse (ovf_pulse),
        .udf_pulse (udf_pulse)
    );

    // Bus decode: only the access phase matters; bad addresses and TCNT writes error out.
    always_comb begin
        access  = psel && penable;
        addr_ok = (paddr <= ADDR_TCNT);
        slv_err = access && (!addr_ok || (pwrite && (paddr == ADDR_TCNT)));
        wr_en   = access && pwrite && !slv_err;
        rd_en   = access && !pwrite && !slv_err;
    end

    // Register next-state: bus writes, one-cycle load pulse, sticky flags with set winning over W1C.
    always_comb begin
        tdr_d    = tdr_q;
        en_d     = en_q;
        updown_d = updown_q;
        cks_d    = cks_q;
        tie_d    = tie_q;
        load_d   = 1'b0;
        tsr_d    = tsr_q;
        if (wr_en) begin
            case (paddr)
                ADDR_TDR: tdr_d = pwdata;
                ADDR_TCR: begin
                    en_d     = pwdata[TCR_EN_BIT];
                    updown_d = pwdata[TCR_UPDOWN_BIT];
                    cks_d    = pwdata[TCR_CKS_MSB:TCR_CKS_LSB];
                    load_d   = pwdata[TCR_LOAD_BIT];
                end
                ADDR_TSR: begin
                    if (pwdata[TSR_OVF_BIT]) tsr_d[TSR_OVF_BIT] = 1'b0;
                    if (pwdata[TSR_UDF_BIT]) tsr_d[TSR_UDF_BIT] = 1'b0;
                end
                ADDR_TIE: tie_d = pwdata;
                default: ;
            endcase
        end
        if (ovf_pulse) tsr_d[TSR_OVF_BIT] = 1'b1;
        if (udf_pulse) tsr_d[TSR_UDF_BIT] = 1'b1;
    end

    // Register state, cleared asynchronously so a reset mid-transfer commits nothing.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tdr_q    <= '0;
            en_q     <= 1'b0;
            updown_q <= 1'b0;
            cks_q    <= 2'b00;
            load_q   <= 1'b0;
            tsr_q    <= 2'b00;
            tie_q    <= '0;
        end else begin
            tdr_q    <= tdr_d;
            en_q     <= en_d;
            updown_q <= updown_d;
            cks_q    <= cks_d;
            load_q   <= load_d;
            tsr_q    <= tsr_d;
            tie_q    <= tie_d;
        end
    end

    // Read-data selection; load reads back 0 and unused status/control bits read 0.
    always_comb begin
        rd_mux = '0;
        case (paddr)
            ADDR_TDR: rd_mux = tdr_q;
            ADDR_TCR: begin
                rd_mux[TCR_EN_BIT]              = en_q;
                rd_mux[TCR_UPDOWN_BIT]          = updown_q;
                rd_mux[TCR_CKS_MSB:TCR_CKS_LSB] = cks_q;
            end
            ADDR_TSR: begin
                rd_mux[TSR_OVF_BIT] = tsr_q[TSR_OVF_BIT];
                rd_mux[TSR_UDF_BIT] = tsr_q[TSR_UDF_BIT];
            end
            ADDR_TIE:  rd_mux = tie_q;
            ADDR_TCNT: rd_mux = cnt;
            default:   rd_mux = '0;
        endcase
    end

    // Output drive; bus responses are forced quiet while reset is held.
    always_comb begin
        pready  = access;
        pslverr = slv_err && preset_n;
        prdata  = (rd_en && preset_n) ? rd_mux : '0;
        en      = en_q;
        load    = load_q;
        updown  = updown_q;
        cks     = cks_q;
        tdr     = tdr_q;
        tmr_ovf = tsr_q[TSR_OVF_BIT] & tie_q[TSR_OVF_BIT];
        tmr_udf = tsr_q[TSR_UDF_BIT] & tie_q[TSR_UDF_BIT];
    end

endmodule

// File: tb/tb_timer_reg_if.sv
// Directed self-checking bench for timer_reg_if: register access, load pulse,
// wrap flags with W1C, load suppression, bus errors and mid-transfer reset.
module tb_timer_reg_if;

    logic       pclk;
    logic       preset_n;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       en;
    logic       load;
    logic       updown;
    logic [1:0] cks;
    logic [7:0] tdr;
    logic [7:0] cnt;
    logic       tmr_ovf;
    logic       tmr_udf;

    int checks = 0;
    int errors = 0;

    timer_reg_if #(.CNT_W(8)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .en       (en),
        .load     (load),
        .updown   (updown),
        .cks      (cks),
        .tdr      (tdr),
        .cnt      (cnt),
        .tmr_ovf  (tmr_ovf),
        .tmr_udf  (tmr_udf)
    );

    // 100 MHz clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Drive the counter input at a falling edge and let one rising edge pass.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge pclk);
        cnt = value;
        @(posedge pclk);
        #1;
    endtask

    // Full APB write; returns one time unit after the commit edge.
    task automatic apbWrite(input logic [7:0] addr, input logic [7:0] data, input logic exp_err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        checkOutput("wr_pready", {7'b0, pready}, 8'h01);
        checkOutput("wr_pslverr", {7'b0, pslverr}, {7'b0, exp_err});
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Full APB read with checks of setup-phase quietness and access-phase response.
    task automatic apbRead(input string tag, input logic [7:0] addr, input logic [7:0] exp_data,
                           input logic exp_err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        #1;
        checkOutput({tag, "_setup_prdata"}, prdata, 8'h00);
        checkOutput({tag, "_setup_pslverr"}, {7'b0, pslverr}, 8'h00);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        checkOutput({tag, "_pslverr"}, {7'b0, pslverr}, {7'b0, exp_err});
        checkOutput({tag, "_prdata"}, prdata, exp_data);
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        preset_n = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h07; pwdata = 8'h00;
        cnt = 8'h00;

        // Reset state, with an unmapped read on the bus that must stay silent
        #12;
        checkOutput("rst_pslverr", {7'b0, pslverr}, 8'h00);
        checkOutput("rst_prdata", prdata, 8'h00);
        checkOutput("rst_en", {7'b0, en}, 8'h00);
        checkOutput("rst_load", {7'b0, load}, 8'h00);
        checkOutput("rst_tdr", tdr, 8'h00);
        checkOutput("rst_irq", {6'b0, tmr_udf, tmr_ovf}, 8'h00);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;

        // Control setup and one-cycle load pulse
        apbWrite(8'h00, 8'h03, 1'b0);
        apbWrite(8'h01, 8'h0F, 1'b0);
        checkOutput("load_pulse", {7'b0, load}, 8'h01);
        checkOutput("tdr_out", tdr, 8'h03);
        checkOutput("ctrl_out", {3'b0, cks, updown, 1'b0, en}, 8'h0D);
        @(posedge pclk);
        #1;
        checkOutput("load_clear", {7'b0, load}, 8'h00);
        apbRead("tcr_rd", 8'h01, 8'h0D, 1'b0);

        // Setup-only cycles must not write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
        @(negedge pclk);
        @(negedge pclk);
        psel = 1'b0; pwrite = 1'b0;
        apbRead("setup_only", 8'h00, 8'h03, 1'b0);

        // Overflow counting up, then W1C clear
        apbWrite(8'h03, 8'h01, 1'b0);
        applyStimulus(8'hFE);
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        checkOutput("ovf_irq", {7'b0, tmr_ovf}, 8'h01);
        apbRead("tsr_ovf", 8'h02, 8'h01, 1'b0);
        apbWrite(8'h02, 8'h01, 1'b0);
        apbRead("tsr_clr", 8'h02, 8'h00, 1'b0);
        checkOutput("ovf_irq_clr", {7'b0, tmr_ovf}, 8'h00);

        // Underflow counting down with a coinciding W1C: set wins
        apbWrite(8'h03, 8'h00, 1'b0);
        apbWrite(8'h01, 8'h01, 1'b0);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h02;
        @(negedge pclk);
        penable = 1'b1;
        cnt = 8'hFF;
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apbRead("udf_setwin", 8'h02, 8'h02, 1'b0);
        checkOutput("udf_irq_masked", {7'b0, tmr_udf}, 8'h00);
        apbWrite(8'h03, 8'h02, 1'b0);
        checkOutput("udf_irq", {7'b0, tmr_udf}, 8'h01);
        apbWrite(8'h02, 8'h01, 1'b0);
        apbRead("w1c_zero_keeps", 8'h02, 8'h02, 1'b0);
        apbWrite(8'h02, 8'h02, 1'b0);
        apbRead("udf_clr", 8'h02, 8'h00, 1'b0);

        // Load to 0xFF while counting down is not an underflow
        apbWrite(8'h00, 8'hFF, 1'b0);
        applyStimulus(8'h00);
        apbWrite(8'h01, 8'h03, 1'b0);
        checkOutput("load2_pulse", {7'b0, load}, 8'h01);
        @(posedge pclk);
        #1;
        cnt = 8'hFF;
        @(posedge pclk);
        #1;
        apbRead("load_no_udf", 8'h02, 8'h00, 1'b0);
        apbRead("tcr_load_rd", 8'h01, 8'h01, 1'b0);

        // Disabled counter never flags
        apbWrite(8'h01, 8'h00, 1'b0);
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        apbRead("dis_no_udf", 8'h02, 8'h00, 1'b0);

        // Live count readback
        applyStimulus(8'h5A);
        apbRead("tcnt_rd", 8'h04, 8'h5A, 1'b0);

        // Bus errors change nothing
        apbRead("bad_rd", 8'h07, 8'h00, 1'b1);
        apbWrite(8'h04, 8'h77, 1'b1);
        apbWrite(8'h09, 8'h55, 1'b1);
        apbRead("err_tdr", 8'h00, 8'hFF, 1'b0);
        apbRead("err_tcr", 8'h01, 8'h00, 1'b0);
        apbRead("err_tie", 8'h03, 8'h02, 1'b0);
        apbRead("err_tsr", 8'h02, 8'h00, 1'b0);

        // Reset in the access phase of a TCR write
        apbWrite(8'h01, 8'h05, 1'b0);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h0F;
        @(negedge pclk);
        penable = 1'b1;
        #2;
        preset_n = 1'b0;
        #140;
        checkOutput("mid_rst_ctrl", {3'b0, cks, updown, load, en}, 8'h00);
        checkOutput("mid_rst_tdr", tdr, 8'h00);
        checkOutput("mid_rst_bus", {5'b0, tmr_udf, tmr_ovf, pslverr}, 8'h00);
        checkOutput("mid_rst_prdata", prdata, 8'h00);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        @(posedge pclk);
        #1;
        checkOutput("post_rst_load", {7'b0, load}, 8'h00);
        apbRead("post_rst_tcr", 8'h01, 8'h00, 1'b0);
        apbWrite(8'h00, 8'h42, 1'b0);
        apbRead("post_rst_tdr", 8'h00, 8'h42, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
